// File: rtl/in_port_pkg.sv
// Shared constants and helpers for the buffered multi-channel CPU input port.
// Optional interrupt output is enabled by defining IN_PORT_IRQ_EN.
package in_port_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int CHANNELS_DEF = 4;
  localparam int DEPTH_DEF    = 8;

  // A one-channel array still needs a 1-bit select port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/in_port_fifo.sv
// Single-channel synchronous FIFO with registered ready; storage is not reset.
// Part of in_port_array (IN_PORT_IRQ_EN has no effect on this file).
module in_port_fifo
  import in_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic              pop_req,
  output logic [DATA_W-1:0] head,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_next;
  logic              r_ready;
  logic              w_push;
  logic              w_pop;

  assign empty      = (r_count == '0);
  assign w_push     = push_valid && r_ready;
  assign w_pop      = pop_req && !empty;
  assign push_ready = r_ready;
  assign head       = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      // Looking at the next count lets a pop reopen ready on the same edge.
      r_ready <= (w_count_next < CW'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/in_port_array.sv
// Multi-channel buffered CPU input port: per-channel FIFOs, sel mux, sticky underflow.
// Define IN_PORT_IRQ_EN to add irq_mask/irq (registered "any unmasked channel non-empty").
module in_port_array
  import in_port_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int CHANNELS = CHANNELS_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  localparam int SW       = clog2_min1(CHANNELS)
) (
  input  logic                       clock,
  input  logic                       clear_n,
  input  logic [CHANNELS*DATA_W-1:0] ext_data,
  input  logic [CHANNELS-1:0]        ext_valid,
  output logic [CHANNELS-1:0]        ext_ready,
  input  logic [SW-1:0]              sel,
  input  logic                       InPort_Out,
  output logic [DATA_W-1:0]          bus_out,
  output logic [CHANNELS-1:0]        empty,
  output logic [CHANNELS-1:0]        underflow,
`ifdef IN_PORT_IRQ_EN
  input  logic [CHANNELS-1:0]        irq_mask,
  output logic                       irq,
`endif
  input  logic                       status_clr
);

  logic [CHANNELS-1:0] w_rd;
  logic [CHANNELS-1:0] w_ready;
  logic [CHANNELS-1:0] w_empty;
  logic [DATA_W-1:0]   w_head [CHANNELS];
  logic [DATA_W-1:0]   w_bus;
  logic                w_sel_ok;
  logic [CHANNELS-1:0] r_underflow;

  // Selects beyond the last channel behave as a permanently empty channel.
  if ((1 << SW) == CHANNELS) begin : g_sel_full
    assign w_sel_ok = 1'b1;
  end else begin : g_sel_part
    assign w_sel_ok = ({1'b0, sel} < (SW+1)'(CHANNELS));
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_rd[c] = InPort_Out && w_sel_ok && (sel == SW'(c));

    in_port_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clock      (clock),
      .clear_n    (clear_n),
      .push_data  (ext_data[c*DATA_W +: DATA_W]),
      .push_valid (ext_valid[c]),
      .push_ready (w_ready[c]),
      .pop_req    (w_rd[c]),
      .head       (w_head[c]),
      .empty      (w_empty[c])
    );
  end

  // bus_out is ORed into the CPU bus, so it must be zero when not driving.
  always_comb begin
    w_bus = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_rd[c] && !w_empty[c]) w_bus = w_head[c];
    end
  end

  assign bus_out   = w_bus;
  assign ext_ready = w_ready;
  assign empty     = w_empty;
  assign underflow = r_underflow;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_underflow <= '0;
    end else begin
      r_underflow <= (status_clr ? '0 : r_underflow) | (w_rd & w_empty);
    end
  end

`ifdef IN_PORT_IRQ_EN
  logic r_irq;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(~w_empty & irq_mask);
    end
  end

  assign irq = r_irq;
`endif

endmodule
